// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer
//
// This block dims the 4-bit flow-LED pattern from the upstream generator with
// PWM. A debounced push-button steps the brightness level.
//
// A PWM frame is 15 steps of PRESCALE clocks each. The pattern and the duty
// value are latched only on the last clock of a frame. As a result, changes to
// the pattern or the brightness never show up part-way through a frame.
//
// Optional feature: define LED_PWM_GAMMA_EN to map the brightness level
// through a perceptual table. Without it, duty equals the level (linear).
//
// Parameters:
//   PRESCALE      sys_clk cycles per PWM step (>= 1)
//   DEBOUNCE_CYC  cycles the key must hold a new value to be accepted (>= 2)
//   RESET_LEVEL   brightness level loaded at reset (0..15)
//
// Ports:
//   sys_clk      system clock
//   sys_rst      synchronous active-high reset
//   led_in       [3:0] pattern from the flow-LED generator, 1 = lit
//   key_n        asynchronous push-button, active low
//   led_out      [3:0] PWM-modulated LED pins, 1 = lit
//   level        [3:0] current brightness level
//   frame_start  one-cycle pulse on the first output cycle of each frame
module led_pwm_dimmer #(
  parameter int PRESCALE     = 50,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int RESET_LEVEL  = 15
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] led_in,
  input  logic       key_n,
  output logic [3:0] led_out,
  output logic [3:0] level,
  output logic       frame_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [3:0]       RST_LVL = 4'(RESET_LEVEL);
  localparam logic [3:0]       LAST_STEP = 4'd14;

  function automatic logic [3:0] duty_map(input logic [3:0] lvl);
`ifdef LED_PWM_GAMMA_EN
    logic [3:0] d;
    case (lvl)
      4'd0:    d = 4'd0;
      4'd1:    d = 4'd1;
      4'd2:    d = 4'd1;
      4'd3:    d = 4'd1;
      4'd4:    d = 4'd2;
      4'd5:    d = 4'd2;
      4'd6:    d = 4'd3;
      4'd7:    d = 4'd4;
      4'd8:    d = 4'd5;
      4'd9:    d = 4'd6;
      4'd10:   d = 4'd7;
      4'd11:   d = 4'd8;
      4'd12:   d = 4'd10;
      4'd13:   d = 4'd11;
      4'd14:   d = 4'd13;
      default: d = 4'd15;
    endcase
    return d;
`else
    return lvl;
`endif
  endfunction

  logic [PRE_W-1:0] pre;
  logic [3:0]       step;
  logic [3:0]       pat;
  logic [3:0]       duty;
  logic             step_end;
  logic             frame_end;

  assign step_end  = (pre == PRE_MAX);
  assign frame_end = step_end && (step == LAST_STEP);

  // Stage p0: frame timing and latching of pattern/duty at frame boundaries
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pre  <= '0;
      step <= '0;
      pat  <= '0;
      duty <= duty_map(RST_LVL);
    end else begin
      pre <= step_end ? '0 : pre + 1'b1;
      if (step_end) begin
        step <= (step == LAST_STEP) ? 4'd0 : step + 4'd1;
      end
      // level here is the pre-increment value when a press lands on this cycle
      if (frame_end) begin
        pat  <= led_in;
        duty <= duty_map(level);
      end
    end
  end

  // Stage p1: registered pins; frame_start lines up with the first step-0 output
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      led_out     <= pat & {4{step < duty}};
      frame_start <= (pre == '0) && (step == 4'd0);
    end
  end

  logic             sync_p0;
  logic             sync_p1;
  logic             key_stable;
  logic             key_stable_d;
  logic [CNT_W-1:0] cnt;
  logic             press;

  // Stage p0/p1: two-flop synchronizer for the asynchronous key
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce; any return to the stable value restarts the count
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_stable <= 1'b1;
      cnt        <= '0;
    end else if (sync_p1 == key_stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      key_stable <= sync_p1;
      cnt        <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Only the falling edge of the debounced key (a press) steps the level
  assign press = key_stable_d & ~key_stable;

  // Stage p3: brightness level, 15 wraps to 0
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_stable_d <= 1'b1;
      level        <= RST_LVL;
    end else begin
      key_stable_d <= key_stable;
      if (press) begin
        level <= level + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
module tb_led_pwm_dimmer;

  localparam int P     = 2;
  localparam int DEB   = 4;
  localparam int RL    = 15;
  localparam int FRAME = 15 * P;

`ifdef LED_PWM_GAMMA_EN
  localparam int LIT_L5  = 2 * 2;
  localparam int LIT_L12 = 2 * 10;
`else
  localparam int LIT_L5  = 2 * 5;
  localparam int LIT_L12 = 2 * 12;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] led_in;
  logic       key_n;
  logic [3:0] led_out;
  logic [3:0] level;
  logic       frame_start;

  always #5 clk = ~clk;

  led_pwm_dimmer #(
    .PRESCALE(P),
    .DEBOUNCE_CYC(DEB),
    .RESET_LEVEL(RL)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .led_in(led_in),
    .key_n(key_n),
    .led_out(led_out),
    .level(level),
    .frame_start(frame_start)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] map_lvl(input logic [3:0] l);
`ifdef LED_PWM_GAMMA_EN
    logic [3:0] tbl [16] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4,
                             4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11, 4'd13, 4'd15};
    return tbl[l];
`else
    return l;
`endif
  endfunction

  // Frame-level model: cycle n after reset sits at frame position (n-1) mod FRAME.
  // Each frame shows the pattern/level captured on the final cycle of the previous one.
  bit         model_on = 0;
  int         n;
  int         pos;
  logic [3:0] m_pat, m_duty, m_lvl, exp_led;
  bit         exp_fs;
  // key_n samples from one and two cycles back
  logic       h0, h1, ks;
  logic       stable;
  int         run;
  bit         pend;

  always @(posedge clk) begin
    if (rst) begin
      model_on = 1;
      n = 0;
      m_pat = 4'd0;
      m_lvl = 4'(RL);
      m_duty = map_lvl(m_lvl);
      exp_led = 4'd0;
      exp_fs = 0;
      h0 = 1'b1;
      h1 = 1'b1;
      stable = 1'b1;
      run = 0;
      pend = 0;
    end else if (model_on) begin
      n++;
      pos = (n - 1) % FRAME;
      exp_led = ((pos / P) < int'(m_duty)) ? m_pat : 4'd0;
      exp_fs = (pos == 0);
      if (pos == FRAME - 1) begin
        m_pat = led_in;
        m_duty = map_lvl(m_lvl);
      end
      if (pend) m_lvl = m_lvl + 4'd1;
      pend = 0;
      ks = h1;
      h1 = h0;
      h0 = key_n;
      if (ks != stable) begin
        run++;
        if (run == DEB) begin
          stable = ks;
          run = 0;
          if (stable == 1'b0) pend = 1;
        end
      end else begin
        run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("led_out", 32'(led_out), 32'(exp_led));
      chk("frame_start", 32'(frame_start), 32'(exp_fs));
      chk("level", 32'(level), 32'(m_lvl));
    end
  end

  task automatic wait_fs();
    bit ok = 0;
    for (int i = 0; i < 2 * FRAME + 5 && !ok; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) ok = 1;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL fs_timeout: got no frame_start, required one within %0d cycles", 2 * FRAME + 5);
    end
  endtask

  task automatic count_frame(output int lit, output logic [3:0] orp);
    wait_fs();
    lit = 0;
    orp = 4'd0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (led_out != 4'd0) lit++;
      orp = orp | led_out;
    end
  endtask

  task automatic press();
    key_n = 1'b0;
    repeat (10) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  int         lit;
  logic [3:0] orp;
  int         period;

  initial begin
    rst = 1'b1;
    led_in = 4'b1111;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_led_out", 32'(led_out), 32'd0);
    chk("rst_level", 32'(level), 32'd15);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    rst = 1'b0;

    // first frame after reset is dark, then full on
    count_frame(lit, orp);
    chk("first_frame_lit", 32'(lit), 32'd0);
    count_frame(lit, orp);
    chk("second_frame_lit", 32'(lit), 32'd30);
    chk("second_frame_pat", 32'(orp), 32'b1111);

    // duty: 6 presses from 15 wraps through 0 to 5
    repeat (6) press();
    chk("level_after_6", 32'(level), 32'd5);
    led_in = 4'b0101;
    count_frame(lit, orp);
    count_frame(lit, orp);
    chk("duty5_lit", 32'(lit), 32'(LIT_L5));
    chk("duty5_pat", 32'(orp), 32'b0101);
    wait_fs();
    period = 0;
    for (int i = 0; i < 2 * FRAME && (period == 0 || frame_start !== 1'b1); i++) begin
      @(negedge clk);
      period++;
    end
    chk("frame_period", 32'(period), 32'd30);

    // mid-frame pattern change holds until the next frame
    led_in = 4'b0001;
    count_frame(lit, orp);
    wait_fs();
    orp = led_out;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 6) led_in = 4'b1000;
      orp = orp | led_out;
    end
    chk("midframe_old_pat", 32'(orp), 32'b0001);
    @(negedge clk);
    chk("midframe_fs", 32'(frame_start), 32'd1);
    chk("midframe_new_pat", 32'(led_out), 32'b1000);

    // debounce: short glitch, bounce, then a held press
    chk("deb_before", 32'(level), 32'd5);
    key_n = 1'b0;
    repeat (3) @(negedge clk);
    key_n = 1'b1;
    @(negedge clk);
    key_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("deb_6_cycles", 32'(level), 32'd5);
    @(negedge clk);
    chk("deb_7_cycles", 32'(level), 32'd6);
    repeat (100) @(negedge clk);
    chk("deb_held", 32'(level), 32'd6);
    key_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("deb_release", 32'(level), 32'd6);

    // wrap 15 -> 0 and a fully dark frame
    repeat (9) press();
    chk("level_15", 32'(level), 32'd15);
    press();
    chk("level_wrap", 32'(level), 32'd0);
    wait_fs();
    count_frame(lit, orp);
    chk("wrap_frame_lit", 32'(lit), 32'd0);

    // level 12: 24 cycles lit linear, 20 with the gamma table
    repeat (12) press();
    chk("level_12", 32'(level), 32'd12);
    count_frame(lit, orp);
    count_frame(lit, orp);
    chk("level12_lit", 32'(lit), 32'(LIT_L12));
    chk("level12_pat", 32'(orp), 32'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/led_pwm_dimmer.md
# led_pwm_dimmer

Brightness stage downstream of the flow-LED pattern generator. Takes the generator's 4-bit LED pattern and drives the board LED pins with a PWM-dimmed copy of it. Brightness is a 4-bit level stepped by a debounced push-button. Pattern and duty are latched only at PWM frame boundaries, so the pins never glitch mid-frame.

## Interface
- `PRESCALE`, 50 — sys_clk cycles per PWM step (≥1); a frame is 15 steps.
- `DEBOUNCE_CYC`, 1_000_000 — cycles the synchronized key must differ from its stable value before the change is accepted (≥2).
- `RESET_LEVEL`, 15 — brightness level loaded at reset (0..15).
- `sys_clk` in 1 — system clock, the only clock.
- `sys_rst` in 1 — synchronous, active-high reset.
- `led_in` in 4 — LED pattern from the upstream flow-LED generator; 1 = lit.
- `key_n` in 1 — asynchronous push-button, active low.
- `led_out` out 4 — PWM-modulated LED pins; 1 = lit.
- `level` out 4 — current brightness level.
- `frame_start` out 1 — one-cycle pulse on the first cycle of every PWM frame.

## Operation
- **Prescaler `pre`:** counts 0..PRESCALE-1 and wraps.
- **Step counter `step`:** counts 0..14. It advances only when `pre == PRESCALE-1`; 14 wraps to 0.
- **Frame latch:** when `pre == PRESCALE-1` and `step == 14`, load `pat <= led_in` and `duty <= map(level)`.
  - Values sampled on that cycle apply from the next step 0.
  - Changes to `led_in` or `level` never take effect mid-frame.
- **Output:** `led_out[i] <= pat[i] & (step < duty)`, registered.
  - duty 0 → always off; duty 15 → always on; duty d → lit for d of 15 steps.
- **`frame_start`:** registered; high for exactly one cycle, coincident with the first `led_out` cycle of step 0.
- **Key path:**
  - 2-FF synchronizer gives `key_s`.
  - If `key_s == key_stable`: `cnt <= 0`.
  - Otherwise `cnt <= cnt + 1`. When `cnt == DEBOUNCE_CYC-1`: `key_stable <= key_s`, `cnt <= 0`.
  - Any bounce back to the stable value clears `cnt`.
- **Level stepping:**
  - A 1→0 transition of `key_stable` (press) increments `level` on the next cycle.
  - 15 wraps to 0.
  - Release (0→1) has no effect; a held key gives exactly one increment.
- **Counter widths:** `pre` is clog2(PRESCALE) bits; `cnt` is clog2(DEBOUNCE_CYC) bits; both zero-extended.

## Timing
- **Reset values:** `pre = 0`, `step = 0`, `pat = 0`, `duty = map(RESET_LEVEL)`, `led_out = 0`, `frame_start = 0`, `level = RESET_LEVEL`, sync FFs and `key_stable` = 1, `cnt = 0`.
- **Reset mid-frame:** all of the above apply on the next edge. The first frame after reset emits `pat = 0`, so LEDs stay dark until the first latch.
- **Latency `led_in` → `led_out`:** first visible at the frame after the latch, i.e. 1 to 15·PRESCALE cycles, plus 1 output register.
- **Latency key → `level`:**
  - 2 sync cycles + DEBOUNCE_CYC cycles + 1.
  - `level` is visible at pins at the next frame latch.
- **Press on the latch cycle:** the latch uses the pre-increment level; the new level applies one frame later.
- **Frame period:** exactly 15·PRESCALE cycles. `frame_start` repeats at that period with no jitter.

## Configuration
- **`LED_PWM_GAMMA_EN` defined:** `map(level)` is a perceptual table for levels 0..15 → 0,1,1,1,2,2,3,4,5,6,7,8,10,11,13,15.
- **`LED_PWM_GAMMA_EN` undefined:** `map(level) = level` (linear).
- **Unaffected either way:** interface and timing.

## Test plan
All scenarios use PRESCALE=2, DEBOUNCE_CYC=4, RESET_LEVEL=15, gamma off.
- **Reset:** assert `sys_rst` for 3 cycles with `led_in = 4'b1111`.
  - `led_out = 0`, `level = 15`, `frame_start = 0` during reset.
  - `led_out = 0` for the first 30-cycle frame, then 4'b1111 continuously.
- **Duty:** force `level` to 5 via 6 presses from 15 (wrap through 0); `led_in = 4'b0101`.
  - Each frame: `led_out = 4'b0101` for 10 cycles, then 0 for 20 cycles.
  - `frame_start` pulses every 30 cycles.
- **Mid-frame change:** change `led_in` from 4'b0001 to 4'b1000 at step 3.
  - The current frame keeps 4'b0001.
  - 4'b1000 appears exactly at the next `frame_start`.
- **Debounce:** drive `key_n` low for 3 cycles, high 1 cycle, low for 10 cycles.
  - Exactly one `level` increment, 7 cycles after the final falling edge (2 sync + 4 debounce + 1).
  - Hold for 100 cycles → no further change.
- **Wrap:** `level = 15`, one clean press → `level = 0`; the next frame has `led_out = 0` for the full frame.
- **Gamma build:** with `LED_PWM_GAMMA_EN`, `level = 12` → lit 10 of 15 steps (20 of 30 cycles).
